// File: rtl/digit_emitter.sv
// Converts an 8-bit value to BCD (shift-add-3, one bit per cycle) and emits hundreds, tens, units as
// spaced strobed digits. Define DIGIT_EMIT_BLANK_EN to emit leading zeros as the blank code 5'd16.
module digit_emitter #(
  parameter int GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] valor,
  output logic [4:0] digito,
  output logic       cambio_digito,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, CONVERT, SEND, HOLD, FIN} state_t;

  localparam logic [4:0] BLANK     = 5'd16;
  localparam logic [3:0] HOLD_LAST = 4'(GAP - 2);

  state_t      state_q;
  logic [11:0] bcd_q;
  logic [7:0]  bin_q;
  logic [2:0]  cnt_q;
  logic [1:0]  idx_q;
  logic [3:0]  hold_q;
  logic [4:0]  digito_q;
  logic        cambio_q;
  logic        busy_q;
  logic        done_q;

  logic [11:0] bcd_adj;
  logic [19:0] shift_d;

  // One double-dabble step: correct each BCD nibble, then shift the whole {bcd, bin} word left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
    shift_d = {bcd_adj[10:0], bin_q, 1'b0};
  end

  function automatic logic [4:0] digit_of(input logic [11:0] bcd, input logic [1:0] idx);
    logic [4:0] d;
    case (idx)
      2'd0:    d = {1'b0, bcd[11:8]};
      2'd1:    d = {1'b0, bcd[7:4]};
      default: d = {1'b0, bcd[3:0]};
    endcase
`ifdef DIGIT_EMIT_BLANK_EN
    if (idx == 2'd0 && bcd[11:8] == 4'd0) d = BLANK;
    if (idx == 2'd1 && bcd[11:4] == 8'd0) d = BLANK;
`endif
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      digito_q <= BLANK;
      cambio_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cambio_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= valor;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q + 3'd1;
          // The eighth step finishes here, so the first digit comes straight from the step result.
          if (cnt_q == 3'd7) begin
            idx_q    <= 2'd0;
            digito_q <= digit_of(shift_d[19:8], 2'd0);
            cambio_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          hold_q  <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          hold_q <= hold_q + 4'd1;
          if (hold_q == HOLD_LAST) begin
            if (idx_q == 2'd2) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIN;
            end else begin
              idx_q    <= idx_q + 2'd1;
              digito_q <= digit_of(bcd_q, idx_q + 2'd1);
              cambio_q <= 1'b1;
              state_q  <= SEND;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digito        = digito_q;
  assign cambio_digito = cambio_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_digit_emitter.sv
// Bench for digit_emitter: two instances (GAP=4 and GAP=2) share stimulus and are checked every
// cycle against a timeline model, with literal digit/timing expectations after each directed case.
module tb_digit_emitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] valor = 8'd0;

  logic [4:0] digito0, digito1;
  logic       cambio0, cambio1, busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  digit_emitter #(.GAP(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .valor(valor),
    .digito(digito0), .cambio_digito(cambio0), .busy(busy0), .done(done0)
  );

  digit_emitter #(.GAP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .valor(valor),
    .digito(digito1), .cambio_digito(cambio1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int g);
    return (g == 0) ? 4 : 2;
  endfunction

  function automatic int exp_digit(input int v, input int j);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
`ifdef DIGIT_EMIT_BLANK_EN
    if (j == 0) return (h == 0) ? 16 : h;
    if (j == 1) return (h == 0 && t == 0) ? 16 : t;
`else
    if (j == 0) return h;
    if (j == 1) return t;
`endif
    return u;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Model: k counts edges since acceptance; the outputs observed after edge k follow from the timeline.
  bit m_act[2]    = '{0, 0};
  int m_k[2]      = '{0, 0};
  int m_dig[2][3];
  int m_digito[2] = '{16, 16};

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      int gp;
      gp = gap_of(g);
      if (!rst_n) begin
        m_act[g]    = 0;
        m_digito[g] = 16;
      end else begin
        if (m_act[g] && m_k[g] == 9 + 3 * gp) m_act[g] = 0;
        if (!m_act[g]) begin
          if (start) begin
            m_act[g] = 1;
            m_k[g]   = 0;
            for (int j = 0; j < 3; j++) m_dig[g][j] = exp_digit(int'(valor), j);
          end
        end else begin
          m_k[g]++;
          for (int j = 0; j < 3; j++)
            if (m_k[g] == 8 + j * gp) m_digito[g] = m_dig[g][j];
        end
      end
    end
  end

  int pdig0[$], pcyc0[$], dcyc0[$];
  int pdig1[$], pcyc1[$], dcyc1[$];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int gp, k, e_busy, e_done, e_camb;
      logic [4:0] a_dig;
      logic a_camb, a_busy, a_done;
      gp = gap_of(g);
      k  = m_k[g];
      e_busy = (m_act[g] && k <= 7 + 3 * gp) ? 1 : 0;
      e_done = (m_act[g] && k == 8 + 3 * gp) ? 1 : 0;
      e_camb = (m_act[g] && (k == 8 || k == 8 + gp || k == 8 + 2 * gp)) ? 1 : 0;
      if (g == 0) begin
        a_dig = digito0; a_camb = cambio0; a_busy = busy0; a_done = done0;
      end else begin
        a_dig = digito1; a_camb = cambio1; a_busy = busy1; a_done = done1;
      end
      chk($sformatf("dut%0d.digito", g), int'(a_dig), m_digito[g]);
      chk($sformatf("dut%0d.cambio", g), int'(a_camb), e_camb);
      chk($sformatf("dut%0d.busy", g), int'(a_busy), e_busy);
      chk($sformatf("dut%0d.done", g), int'(a_done), e_done);
      if (a_camb) begin
        if (g == 0) begin pdig0.push_back(int'(a_dig)); pcyc0.push_back(cyc); end
        else        begin pdig1.push_back(int'(a_dig)); pcyc1.push_back(cyc); end
      end
      if (a_done) begin
        if (g == 0) dcyc0.push_back(cyc);
        else        dcyc1.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    pdig0.delete(); pcyc0.delete(); dcyc0.delete();
    pdig1.delete(); pcyc1.delete(); dcyc1.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go(input int v, output int a);
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    valor = 8'(v);
    @(negedge clk);
    start = 1'b0;
    a = cyc;
  endtask

  // Literal expectations: first three pulses at a+8+j*GAP with the given digits, first done at a+8+3*GAP.
  task automatic check_seq(input int g, input int a, input int d0, input int d1, input int d2);
    int dq[$], cq[$], oq[$];
    int gp, exp_d[3];
    gp = gap_of(g);
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    if (g == 0) begin dq = pdig0; cq = pcyc0; oq = dcyc0; end
    else        begin dq = pdig1; cq = pcyc1; oq = dcyc1; end
    for (int j = 0; j < 3; j++) begin
      if (j < dq.size()) begin
        chk($sformatf("seq%0d.digit%0d", g, j), dq[j], exp_d[j]);
        chk($sformatf("seq%0d.pulse_time%0d", g, j), cq[j] - a, 8 + j * gp);
      end else begin
        chk($sformatf("seq%0d.missing_pulse%0d", g, j), dq.size(), j + 1);
      end
    end
    if (oq.size() > 0) chk($sformatf("seq%0d.done_time", g), oq[0] - a, 8 + 3 * gp);
    else               chk($sformatf("seq%0d.done_seen", g), 0, 1);
  endtask

  task automatic check_counts(input int np0, input int nd0, input int np1, input int nd1);
    chk("count.pulses_dut0", pdig0.size(), np0);
    chk("count.done_dut0", dcyc0.size(), nd0);
    chk("count.pulses_dut1", pdig1.size(), np1);
    chk("count.done_dut1", dcyc1.size(), nd1);
  endtask

  initial begin
    int a;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.digito", int'(digito0), 16);
    chk("reset.busy", int'(busy0), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 173 with restarts at T+5 and T+15 and a valor change after acceptance.
    go(173, a);
    valor = 8'd99;
    wait_until(a + 4);  start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(a + 14); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(a + 30);
    check_seq(0, a, 1, 7, 3);
    check_seq(1, a, 1, 7, 3);
    check_counts(3, 1, 3, 1);
    $display("txn valor=173 accepted at cycle %0d", a);

    go(0, a); wait_until(a + 30);
`ifdef DIGIT_EMIT_BLANK_EN
    check_seq(0, a, 16, 16, 0);
`else
    check_seq(0, a, 0, 0, 0);
`endif
    $display("txn valor=0 accepted at cycle %0d", a);

    go(255, a); wait_until(a + 30);
    check_seq(0, a, 2, 5, 5);
    check_seq(1, a, 2, 5, 5);
    $display("txn valor=255 accepted at cycle %0d", a);

    go(98, a); wait_until(a + 30);
`ifdef DIGIT_EMIT_BLANK_EN
    check_seq(1, a, 16, 9, 8);
`else
    check_seq(1, a, 0, 9, 8);
`endif
    $display("txn valor=98 accepted at cycle %0d", a);

    go(7, a); wait_until(a + 30);
`ifdef DIGIT_EMIT_BLANK_EN
    check_seq(0, a, 16, 16, 7);
`else
    check_seq(0, a, 0, 0, 7);
`endif
    $display("txn valor=7 accepted at cycle %0d", a);

    // start held high through FIN: re-accepted on the first IDLE cycle after FIN.
    go(42, a);
    start = 1'b1;
    wait_until(a + 24);
    start = 1'b0;
    wait_until(a + 60);
    check_counts(6, 2, 6, 2);
    if (pcyc0.size() > 3) chk("held.reaccept_dut0", pcyc0[3] - a, 30);
    if (pcyc1.size() > 3) chk("held.reaccept_dut1", pcyc1[3] - a, 24);
    $display("txn valor=42 held start, accepted at cycle %0d", a);

    // Asynchronous reset mid-emission.
    go(200, a);
    wait_until(a + 12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.digito", int'(digito0), 16);
    chk("arst.cambio", int'(cambio0), 0);
    chk("arst.busy", int'(busy0), 0);
    chk("arst.done", int'(done0), 0);
    chk("arst.busy_dut1", int'(busy1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (25) @(negedge clk);
    check_counts(0, 0, 0, 0);
    $display("txn valor=200 aborted by reset after cycle %0d", a + 12);

    go(56, a); wait_until(a + 30);
`ifdef DIGIT_EMIT_BLANK_EN
    check_seq(0, a, 16, 5, 6);
    check_seq(1, a, 16, 5, 6);
`else
    check_seq(0, a, 0, 5, 6);
    check_seq(1, a, 0, 5, 6);
`endif
    $display("txn valor=56 after reset, accepted at cycle %0d", a);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/digit_emitter.md
DIGIT_EMITTER -- requirements
Module: digit_emitter

Interface
REQ-001 Parameter GAP, default 4, SHALL set the cycle spacing between consecutive cambio_digito pulses; legal range 2..15.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to emit valor as three digits; sampled only in IDLE.
REQ-005 valor  input  8  unsigned binary value 0..255 to emit.
REQ-006 digito  output  5  current digit code; 0..9, or 5'd16 for blank.
REQ-007 cambio_digito  output  1  one-cycle strobe marking a new digit on digito.
REQ-008 busy  output  1  high from the cycle after start acceptance until done.
REQ-009 done  output  1  one-cycle pulse after the third digit's spacing window.

Function
REQ-010 FSM states SHALL be IDLE, CONVERT, SEND, HOLD and FIN.
REQ-011 In IDLE with start=1 at edge T, the block SHALL latch valor, enter CONVERT and assert busy from T+1.
REQ-012 CONVERT SHALL run a sequential shift-add-3 binary-to-BCD conversion for exactly 8 cycles, T+1..T+8, producing hundreds, tens and units digits.
REQ-013 Digits SHALL be emitted hundreds first, then tens, then units, so a shift-register receiver ends with hundreds in its most significant position.
REQ-014 SEND SHALL last one cycle, drive digito with the current digit and assert cambio_digito for that cycle only.
REQ-015 HOLD SHALL last GAP-1 cycles, keep digito stable and keep cambio_digito low.
REQ-016 Pulses SHALL occur at T+9, T+9+GAP and T+9+2*GAP.
REQ-017 FIN SHALL occur at T+9+3*GAP, pulse done for one cycle, drop busy in the same cycle and return to IDLE.
REQ-018 digito SHALL keep its last emitted value after FIN until the next SEND.
REQ-019 Exactly three digits SHALL always be emitted, including for valor=0.
REQ-020 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high through FIN SHALL be accepted in the first IDLE cycle after FIN.
REQ-022 A change on valor after acceptance SHALL NOT affect the digits being emitted.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, digito=5'd16, cambio_digito=0, busy=0 and done=0, aborting any conversion or emission.
REQ-024 After reset release, no pulse SHALL be emitted until a new start is accepted.

Configuration
REQ-025 With DIGIT_EMIT_BLANK_EN defined, leading zero digits SHALL be emitted as 5'd16, the units digit SHALL always be numeric, and timing SHALL be unchanged.
REQ-026 Without DIGIT_EMIT_BLANK_EN, all three digits SHALL be emitted numerically, including leading zeros.

Verification
REQ-027 GAP=4, valor=173, start at T -> digito 1,7,3 with pulses at T+9, T+13 and T+17; done at T+21; busy high T+1..T+20.
REQ-028 valor=0 and valor=255 -> digit sequences 0,0,0 and 2,5,5; with DIGIT_EMIT_BLANK_EN, valor=7 -> 16,16,7.
REQ-029 start re-pulsed at T+5 and T+15 -> ignored; exactly three pulses and one done.
REQ-030 rst_n low at T+12 -> outputs take reset values immediately; no further pulses; a new start after release yields a correct full sequence.
REQ-031 GAP=2, valor=98 -> digits 0,9,8 with pulses 2 cycles apart; digito is stable between pulses.
